// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: opcodes, fetch FSM states and opcode field position shared by the front end
package fetch_stage_pkg;
  localparam logic [4:0] OP_NOP = 5'h00;
  localparam logic [4:0] OP_LDM = 5'h14;
  localparam logic [4:0] OP_LDD = 5'h15;
  localparam logic [4:0] OP_STD = 5'h16;
  localparam int INSTR_OPC_MSB = 15;
  localparam int INSTR_OPC_LSB = 11;
  typedef enum logic [1:0] {FS_VEC_HI, FS_VEC_LO, FS_FETCH, FS_FETCH_IMM} fstate_t;
  function automatic logic is_two_word(input logic [4:0] opc);
    return opc inside {OP_LDM, OP_LDD, OP_STD};
  endfunction
endpackage

// File: rtl/fetch_stage_if_id.sv
// if_id_reg: pipeline register with hold (stall) and bubble (flush, wins over stall) controls
module if_id_reg #(
  parameter int IW = 16,
  parameter int PW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic [IW-1:0] d_instr,
  input  logic [IW-1:0] d_imm,
  input  logic [PW-1:0] d_pc,
  input  logic          d_valid,
  output logic [IW-1:0] q_instr,
  output logic [IW-1:0] q_imm,
  output logic [PW-1:0] q_pc,
  output logic          q_valid
);
  // flush inserts a bubble, stall holds, otherwise capture the new word
  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      q_instr <= '0;
      q_imm   <= '0;
      q_pc    <= '0;
      q_valid <= 1'b0;
    end else if (!stall) begin
      q_instr <= d_instr;
      q_imm   <= d_imm;
      q_pc    <= d_pc;
      q_valid <= d_valid;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC/reset-vector FSM, two-word instruction assembly and IF/ID register
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int PC_W = 32,
  parameter int INSTR_W = 16,
  parameter logic [PC_W-1:0] RST_VEC_ADDR = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [INSTR_W-1:0] if_id_imm,
  output logic [PC_W-1:0]    if_id_pc,
  output logic               if_id_valid,
  output logic [4:0]         if_id_opcode
);
  fstate_t state, state_n;
  logic [PC_W-1:0] pc, pc_n, d_pc;
  logic [INSTR_W-1:0] hold, hold_n, d_instr, d_imm;
  logic d_valid, vec;
  assign vec = (state == FS_VEC_HI) || (state == FS_VEC_LO);
  assign imem_addr = state == FS_VEC_HI ? RST_VEC_ADDR :
                     state == FS_VEC_LO ? RST_VEC_ADDR + PC_W'(1) : pc;
  assign if_id_opcode = if_id_valid ? if_id_instr[INSTR_OPC_MSB:INSTR_OPC_LSB] : OP_NOP;
  // next state, PC, held first word and IF/ID input; branch beats stall outside the vector load
  always_comb begin
    state_n = state;
    pc_n    = pc;
    hold_n  = hold;
    d_instr = '0;
    d_imm   = '0;
    d_pc    = '0;
    d_valid = 1'b0;
    case (state)
      FS_VEC_HI: begin
        pc_n[PC_W-1 -: INSTR_W] = imem_rdata;
        state_n = FS_VEC_LO;
      end
      FS_VEC_LO: begin
        pc_n[INSTR_W-1:0] = imem_rdata;
        state_n = FS_FETCH;
      end
      FS_FETCH: begin
        pc_n = pc + 1'b1;
        if (is_two_word(imem_rdata[INSTR_OPC_MSB:INSTR_OPC_LSB])) begin
          hold_n  = imem_rdata;
          state_n = FS_FETCH_IMM;
        end else begin
          d_instr = imem_rdata;
          d_pc    = pc + 1'b1;
          d_valid = 1'b1;
        end
      end
      default: begin
        pc_n    = pc + 1'b1;
        d_instr = hold;
        d_imm   = imem_rdata;
        d_pc    = pc + 1'b1;
        d_valid = 1'b1;
        state_n = FS_FETCH;
      end
    endcase
    if (!vec && branch_taken) begin
      pc_n    = branch_target;
      state_n = FS_FETCH;
    end else if (!vec && stall) begin
      pc_n    = pc;
      state_n = state;
      hold_n  = hold;
    end
  end
  // FSM, PC and held first word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FS_VEC_HI;
      pc    <= '0;
      hold  <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      hold  <= hold_n;
    end
  end
  if_id_reg #(.IW(INSTR_W), .PW(PC_W)) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .stall   (stall && !vec),
    .flush   (branch_taken && !vec),
    .d_instr (d_instr),
    .d_imm   (d_imm),
    .d_pc    (d_pc),
    .d_valid (d_valid),
    .q_instr (if_id_instr),
    .q_imm   (if_id_imm),
    .q_pc    (if_id_pc),
    .q_valid (if_id_valid)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of vector load, one/two-word fetch, stall, branch, async reset, wrap
module tb_fetch_stage;
  import fetch_stage_pkg::*;
  logic clk = 1'b0, rst = 1'b1, stall = 1'b0, branch_taken = 1'b0;
  logic [31:0] branch_target = '0, imem_addr, if_id_pc;
  logic [15:0] imem_rdata, if_id_instr, if_id_imm;
  logic if_id_valid;
  logic [4:0] if_id_opcode;
  logic [15:0] mem [0:511];
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  assign imem_rdata = mem[imem_addr[8:0]];
  fetch_stage #(.PC_W(32), .INSTR_W(16), .RST_VEC_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_id_instr(if_id_instr), .if_id_imm(if_id_imm), .if_id_pc(if_id_pc),
    .if_id_valid(if_id_valid), .if_id_opcode(if_id_opcode)
  );
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic clear_mem(input logic [15:0] vlo);
    for (int i = 0; i < 512; i++) mem[i] = 16'h0;
    mem[1] = vlo;
  endtask
  task automatic boot();
    stall = 0; branch_taken = 0;
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    step(); step();
  endtask
  task automatic test_reset();
    clear_mem(16'h0020);
    mem[16'h20] = 16'h0801;
    @(negedge clk); rst = 1;
    @(negedge clk);
    total++; if (imem_addr !== 32'h0) $display("FAIL rst_addr got %h exp 0", imem_addr); else passed++;
    total++; if (if_id_valid !== 1'b0 || if_id_instr !== 16'h0 || if_id_pc !== 32'h0 || if_id_imm !== 16'h0)
      $display("FAIL rst_ifid got v=%b i=%h m=%h pc=%h exp zeros", if_id_valid, if_id_instr, if_id_imm, if_id_pc); else passed++;
    total++; if (if_id_opcode !== OP_NOP) $display("FAIL rst_opc got %h exp %h", if_id_opcode, OP_NOP); else passed++;
    rst = 0;
    step();
    total++; if (imem_addr !== 32'h1 || if_id_valid !== 1'b0) $display("FAIL vec_lo got a=%h v=%b exp 1/0", imem_addr, if_id_valid); else passed++;
    step();
    total++; if (imem_addr !== 32'h20 || if_id_valid !== 1'b0) $display("FAIL vec_done got a=%h v=%b exp 20/0", imem_addr, if_id_valid); else passed++;
    step();
    total++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h21 || if_id_instr !== 16'h0801)
      $display("FAIL first_fetch got v=%b pc=%h i=%h exp 1/21/0801", if_id_valid, if_id_pc, if_id_instr); else passed++;
  endtask
  task automatic test_one_word();
    clear_mem(16'h0020);
    mem[16'h20] = 16'h0801; mem[16'h21] = 16'h0802; mem[16'h22] = 16'h0803;
    boot();
    for (int k = 1; k <= 3; k++) begin
      step();
      total++; if (if_id_instr !== 16'h0800 + 16'(k) || if_id_pc !== 32'h20 + 32'(k) || if_id_imm !== 16'h0 || if_id_opcode !== 5'h01)
        $display("FAIL one_word%0d got i=%h pc=%h m=%h o=%h", k, if_id_instr, if_id_pc, if_id_imm, if_id_opcode); else passed++;
    end
  endtask
  task automatic test_two_word();
    clear_mem(16'h0020);
    mem[16'h20] = 16'hA005; mem[16'h21] = 16'hBEEF; mem[16'h22] = 16'hB011; mem[16'h23] = 16'h1234; mem[16'h24] = 16'h0807;
    boot();
    step();
    total++; if (if_id_valid !== 1'b0 || imem_addr !== 32'h21) $display("FAIL ldm_bubble got v=%b a=%h exp 0/21", if_id_valid, imem_addr); else passed++;
    step();
    total++; if (if_id_instr !== 16'hA005 || if_id_imm !== 16'hBEEF || if_id_pc !== 32'h22 || if_id_opcode !== OP_LDM || imem_addr !== 32'h22)
      $display("FAIL ldm got i=%h m=%h pc=%h o=%h a=%h", if_id_instr, if_id_imm, if_id_pc, if_id_opcode, imem_addr); else passed++;
    step();
    total++; if (if_id_valid !== 1'b0) $display("FAIL std_bubble got v=%b exp 0", if_id_valid); else passed++;
    step();
    total++; if (if_id_instr !== 16'hB011 || if_id_imm !== 16'h1234 || if_id_pc !== 32'h24 || if_id_opcode !== OP_STD)
      $display("FAIL std got i=%h m=%h pc=%h o=%h", if_id_instr, if_id_imm, if_id_pc, if_id_opcode); else passed++;
    step();
    total++; if (if_id_instr !== 16'h0807 || if_id_imm !== 16'h0 || if_id_pc !== 32'h25)
      $display("FAIL after_std got i=%h m=%h pc=%h", if_id_instr, if_id_imm, if_id_pc); else passed++;
  endtask
  task automatic test_stall();
    clear_mem(16'h0020);
    for (int k = 0; k < 5; k++) mem[16'h20 + k] = 16'h0801 + 16'(k);
    boot();
    step();
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (imem_addr !== 32'h21 || if_id_instr !== 16'h0801 || if_id_pc !== 32'h21 || if_id_valid !== 1'b1)
        $display("FAIL stall%0d got a=%h i=%h pc=%h v=%b", k, imem_addr, if_id_instr, if_id_pc, if_id_valid); else passed++;
    end
    stall = 0;
    step();
    total++; if (if_id_instr !== 16'h0802 || if_id_pc !== 32'h22) $display("FAIL resume1 got i=%h pc=%h exp 0802/22", if_id_instr, if_id_pc); else passed++;
    step();
    total++; if (if_id_instr !== 16'h0803 || if_id_pc !== 32'h23) $display("FAIL resume2 got i=%h pc=%h exp 0803/23", if_id_instr, if_id_pc); else passed++;
  endtask
  task automatic test_branch();
    clear_mem(16'h0020);
    mem[16'h20] = 16'h0801; mem[16'h21] = 16'h0802; mem[16'h100] = 16'h0809;
    boot();
    step();
    branch_taken = 1; stall = 1; branch_target = 32'h100;
    step();
    total++; if (if_id_valid !== 1'b0 || if_id_instr !== 16'h0 || imem_addr !== 32'h100)
      $display("FAIL br_fetch got v=%b i=%h a=%h exp 0/0000/100", if_id_valid, if_id_instr, imem_addr); else passed++;
    branch_taken = 0; stall = 0;
    step();
    total++; if (if_id_instr !== 16'h0809 || if_id_pc !== 32'h101) $display("FAIL br_target got i=%h pc=%h exp 0809/101", if_id_instr, if_id_pc); else passed++;
    mem[16'h20] = 16'hA005; mem[16'h21] = 16'hBEEF;
    boot();
    step();
    branch_taken = 1; stall = 1;
    step();
    total++; if (if_id_valid !== 1'b0 || if_id_imm !== 16'h0 || imem_addr !== 32'h100)
      $display("FAIL br_imm got v=%b m=%h a=%h exp 0/0000/100", if_id_valid, if_id_imm, imem_addr); else passed++;
    branch_taken = 0; stall = 0;
    step();
    total++; if (if_id_instr !== 16'h0809 || if_id_imm !== 16'h0 || if_id_pc !== 32'h101)
      $display("FAIL br_drop got i=%h m=%h pc=%h exp 0809/0000/101", if_id_instr, if_id_imm, if_id_pc); else passed++;
  endtask
  task automatic test_async_reset();
    clear_mem(16'h0020);
    mem[16'h20] = 16'h0801; mem[16'h21] = 16'hA005; mem[16'h22] = 16'hBEEF;
    mem[16'h30] = 16'h0807;
    boot();
    step(); step();
    #2 rst = 1;
    #1;
    total++; if (imem_addr !== 32'h0 || if_id_valid !== 1'b0 || if_id_instr !== 16'h0)
      $display("FAIL async_rst got a=%h v=%b i=%h exp 0/0/0", imem_addr, if_id_valid, if_id_instr); else passed++;
    mem[1] = 16'h0030;
    @(negedge clk); rst = 0;
    step(); step();
    total++; if (imem_addr !== 32'h30) $display("FAIL reload got a=%h exp 30", imem_addr); else passed++;
    step();
    total++; if (if_id_instr !== 16'h0807 || if_id_imm !== 16'h0 || if_id_pc !== 32'h31)
      $display("FAIL reload_fetch got i=%h m=%h pc=%h exp 0807/0000/31", if_id_instr, if_id_imm, if_id_pc); else passed++;
  endtask
  task automatic test_wrap();
    clear_mem(16'hFFFF);
    mem[0] = 16'hFFFF; mem[16'h1FF] = 16'h0801;
    boot();
    step();
    total++; if (if_id_pc !== 32'h0 || imem_addr !== 32'h0 || if_id_instr !== 16'h0801)
      $display("FAIL wrap got pc=%h a=%h i=%h exp 0/0/0801", if_id_pc, imem_addr, if_id_instr); else passed++;
    step();
    total++; if (if_id_instr !== 16'hFFFF || if_id_valid !== 1'b1 || if_id_opcode !== 5'h1F || if_id_pc !== 32'h1)
      $display("FAIL unknown_op got i=%h v=%b o=%h pc=%h", if_id_instr, if_id_valid, if_id_opcode, if_id_pc); else passed++;
  endtask
  initial begin
    test_reset();
    test_one_word();
    test_two_word();
    test_stall();
    test_branch();
    test_async_reset();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the 5-stage core; directly upstream of the decode control unit.
- Owns the PC and loads the reset vector from instruction memory.
- Assembles two-word instructions (LDM/LDD/STD carry a 16-bit immediate in the following word).
- Presents a registered instruction, immediate, next-PC and opcode to decode, with stall and branch-redirect control.

Parameters:
- PC_W, 32, PC and instruction-memory address width (word addressed)
- INSTR_W, 16, instruction/memory word width
- RST_VEC_ADDR, 0, address of reset-vector high word; low word at RST_VEC_ADDR+1

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hold PC, state and IF/ID contents (from hazard unit)
- branch_taken  in  1  redirect request from a later stage; implies flush
- branch_target  in  PC_W  redirect address
- imem_addr  out  PC_W  instruction memory address (combinational read port)
- imem_rdata  in  INSTR_W  word at imem_addr, valid same cycle
- if_id_instr  out  INSTR_W  registered instruction word
- if_id_imm  out  INSTR_W  registered immediate (0 for one-word instructions)
- if_id_pc  out  PC_W  address following the instruction (return address for CALL/INT)
- if_id_valid  out  1  IF/ID holds a real instruction
- if_id_opcode  out  5  if_id_valid ? if_id_instr[15:11] : OP_NOP; feeds the control unit

Behaviour:
- Reset is asynchronous and active-high. While rst=1: state=VEC_HI, PC=0, if_id_instr=0, if_id_imm=0, if_id_pc=0, if_id_valid=0, hold=0.
- rst asserted mid-operation aborts everything, including a half-fetched two-word instruction.
- States: VEC_HI, VEC_LO, FETCH, FETCH_IMM.
- imem_addr: VEC_HI -> RST_VEC_ADDR; VEC_LO -> RST_VEC_ADDR+1; FETCH/FETCH_IMM -> PC.
- VEC_HI: PC[31:16] <= imem_rdata; go to VEC_LO. if_id_valid=0.
- VEC_LO: PC[15:0] <= imem_rdata; go to FETCH. if_id_valid=0.
- In VEC_HI/VEC_LO, stall and branch_taken are ignored.
- First real fetch is therefore at cycle 3 after reset release.
- FETCH, one-word opcode:
  - IF/ID <= {imem_rdata, imm=0, pc=PC+1, valid=1}
  - PC <= PC+1; remain in FETCH.
- FETCH, two-word opcode (OP_LDM, OP_LDD, OP_STD):
  - hold <= imem_rdata; PC <= PC+1; go to FETCH_IMM.
  - IF/ID gets a bubble (valid=0).
- FETCH_IMM:
  - IF/ID <= {hold, imm=imem_rdata, pc=PC+1, valid=1}
  - PC <= PC+1; go to FETCH.
- Latency: a one-word instruction is visible at IF/ID the cycle after its address is driven. A two-word instruction is visible 2 cycles after its first word's address.
- stall=1 (no branch): PC, state, hold and all IF/ID registers keep their values; imem_addr stays stable.
- branch_taken=1 in FETCH/FETCH_IMM:
  - PC <= branch_target; state <= FETCH; IF/ID <= bubble (valid=0, instr=0, imm=0).
  - A held first word is discarded.
  - Overrides stall in the same cycle, because the branch belongs to an older instruction.
- PC increment wraps modulo 2^PC_W; no detection.
- Opcode classification uses imem_rdata[15:11] only.
- Unknown opcodes are passed through as one-word instructions.

Decomposition:
- Shared package (defines.v) holds:
  - opcode constants OP_LDM, OP_LDD, OP_STD, OP_NOP
  - state encodings FS_VEC_HI, FS_VEC_LO, FS_FETCH, FS_FETCH_IMM
  - INSTR_OPC_MSB/LSB (15/11)
- One natural sub-module, if_id_reg: the IF/ID register with stall (hold) and flush (bubble) controls, reusable for later pipeline registers.
- PC/FSM logic stays in fetch_stage.

Test Plan:
- Reset vector: M[0]=0x0000, M[1]=0x0020, release rst -> imem_addr 0, 1, then 0x20. if_id_valid=0 for 2 cycles, then 1 with if_id_pc=0x21.
- One-word stream: M[0x20..0x22] = three OP_ADD words -> IF/ID shows each on consecutive cycles, if_id_pc=0x21/0x22/0x23.
- Two-word fetch: M[0x20]=OP_LDM word, M[0x21]=0xBEEF -> one bubble cycle, then if_id_instr=LDM word, if_id_imm=0xBEEF, if_id_pc=0x22, next fetch address 0x22.
- Stall: assert stall 3 cycles mid-stream -> PC, imem_addr and IF/ID frozen; stream resumes with no duplicate or skipped instruction.
- Branch: branch_taken=1 with branch_target=0x100 in FETCH_IMM, stall also 1 -> held word dropped, IF/ID bubble, next imem_addr=0x100.
- Async reset in FETCH_IMM -> outputs clear without a clock edge; the vector reload sequence repeats.
